mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning datapath, PC and RAM address width.
REQ-002 The block SHALL have parameter REG_ADDR_W, default 4, meaning register-file address width.
REQ-003 The block SHALL have parameter WAIT_MAX, default 15, meaning maximum RAM wait cycles before timeout, range 1..255.
Ports (name, direction, width, meaning):
REQ-004 The block SHALL have clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have rst, input, 1, reset: synchronous, active-low.
REQ-006 The block SHALL have emo_alu_answer, input, DATA_W, the ALU result; it is the RAM address for memory ops.
REQ-007 The block SHALL have emo_ram_write_data, input, DATA_W, the store data.
REQ-008 The block SHALL have emo_mem_op, input, 2, the memory op: NOP=0, READ=1, WRITE=2, 3 treated as NOP.
REQ-009 The block SHALL have these inputs, passed through to the MEM/WB register: emo_wb_data_op (WB_DATA_OP width), emo_reg_op (REG_OP width), emo_wb_addr (REG_ADDR_W), emo_PC_wb_data (DATA_W), emo_IH_wb_data (DATA_W).
REQ-010 The block SHALL have these registered outputs: mwo_alu_answer, mwo_ram_read_answer, mwo_PC_wb_data, mwo_IH_wb_data (each DATA_W), mwo_wb_addr, mwo_reg_op, mwo_wb_data_op, forming the MEM/WB register.
REQ-011 The block SHALL have the RAM outputs ram_req (1), ram_we (1), ram_addr (DATA_W) and ram_wdata (DATA_W), all registered.
REQ-012 The block SHALL have the RAM inputs ram_ack (1), a one-cycle completion strobe, and ram_rdata (DATA_W), which is valid while ram_ack=1.
REQ-013 The block SHALL have mem_stall, output, 1, combinational; it freezes IF/ID/EX and the EX/MEM register.
REQ-014 The block SHALL have mem_err, output, 1, a registered sticky timeout flag.

Function
REQ-015 FSM states SHALL be IDLE and WAIT.
REQ-016 IDLE with emo_mem_op NOP SHALL load the MEM/WB register from emo_* at the next edge: one-cycle latency, mwo_ram_read_answer=0, mem_stall=0.
REQ-017 IDLE with READ/WRITE SHALL set mem_stall=1 combinationally. At the edge: ram_req<=1, ram_we<=(op==WRITE), ram_addr<=emo_alu_answer, ram_wdata<=emo_ram_write_data, wait counter<=0, state<=WAIT.
REQ-018 In WAIT, ram_req, ram_we, ram_addr and ram_wdata SHALL hold constant; the counter increments each cycle ram_ack=0.
REQ-019 In WAIT with ram_ack=1, mem_stall SHALL be 0 that cycle. At the edge: MEM/WB loads from emo_*, mwo_ram_read_answer<=ram_rdata for READ or 0 for WRITE, ram_req<=0, state<=IDLE.
REQ-020 Each cycle with mem_stall=1, the MEM/WB register SHALL load a bubble: mwo_reg_op=REG_OP NOP, mwo_wb_data_op=WB_DATA_OP_NOP, all data fields 0.
REQ-021 In WAIT with counter==WAIT_MAX-1 and ram_ack=0, the block SHALL take the timeout path: mem_stall=0, mem_err<=1, MEM/WB loads a bubble, ram_req<=0, state<=IDLE.
REQ-022 ram_ack while in IDLE SHALL be ignored.
REQ-023 From the ack/timeout state, a back-to-back memory op SHALL re-enter WAIT only after one IDLE cycle; ram_req SHALL be low for at least one cycle between requests.
REQ-024 The wait counter SHALL be 8 bits and SHALL saturate, never wrap.
REQ-025 mem_err SHALL clear only on reset.

Reset
REQ-026 When rst=0 at an edge: state<=IDLE, ram_req<=0, ram_we<=0, ram_addr<=0, ram_wdata<=0, counter<=0, mem_err<=0, MEM/WB loads a bubble. This applies even mid-WAIT, and ram_req falls at that edge.
REQ-027 While rst=0, mem_stall SHALL be 0.

Structure
REQ-028 The MEM_OP, WB_DATA_OP and REG_OP codes, DATA_ZERO and the bus widths SHALL live in the shared definitions file; no local literals.
REQ-029 The block SHALL contain one sub-module, mem_wait_counter: clear, enable, saturating, with a terminal-count flag.

Verification
REQ-030 ALU op: emo_alu_answer=0x1234, reg_op=REG, wb_addr=3 -> next cycle mwo_alu_answer=0x1234, mwo_wb_addr=3, mem_stall never 1.
REQ-031 READ at addr 0x0040, ack after 3 cycles with rdata=0xBEEF -> mem_stall high for 3 cycles, then mwo_ram_read_answer=0xBEEF, ram_req low the following cycle.
REQ-032 WRITE addr 0x0010 data 0x00FF, ack on the first WAIT cycle -> ram_we=1, ram_wdata=0x00FF, one stall cycle, mwo_ram_read_answer=0.
REQ-033 READ with no ack -> mem_stall high for exactly 15 cycles, then mem_err=1, MEM/WB holds a bubble, state IDLE.
REQ-034 rst=0 on the second WAIT cycle -> next cycle ram_req=0, mem_stall=0, mwo_reg_op=NOP; a late ram_ack is ignored.
REQ-035 Back-to-back READ, READ, each acked after 1 cycle -> ram_req has a one-cycle gap and both read answers arrive in order.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: op encodings, field widths and FSM states.
package mem_stage_pkg;

  localparam int MEM_OP_W     = 2;
  localparam int WB_DATA_OP_W = 2;
  localparam int REG_OP_W     = 2;
  localparam int WAIT_CNT_W   = 8;
  localparam int DATA_W_MAX   = 64;

  // Memory operation requested by the EX/MEM register; code 3 is reserved and behaves as NOP.
  typedef enum logic [MEM_OP_W-1:0] {
    MEM_OP_NOP   = 2'd0,
    MEM_OP_READ  = 2'd1,
    MEM_OP_WRITE = 2'd2,
    MEM_OP_RSVD  = 2'd3
  } mem_op_e;

  // Write-back data source selector.
  localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_NOP = 2'd0;
  localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_ALU = 2'd1;
  localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_MEM = 2'd2;
  localparam logic [WB_DATA_OP_W-1:0] WB_DATA_OP_PC  = 2'd3;

  // Register-file write target.
  localparam logic [REG_OP_W-1:0] REG_OP_NOP = 2'd0;
  localparam logic [REG_OP_W-1:0] REG_OP_REG = 2'd1;
  localparam logic [REG_OP_W-1:0] REG_OP_SP  = 2'd2;
  localparam logic [REG_OP_W-1:0] REG_OP_IH  = 2'd3;

  // Zero word wide enough for any supported datapath; sliced down at the use site.
  localparam logic [DATA_W_MAX-1:0] DATA_ZERO = '0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_access(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
  endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Saturating wait-cycle counter with a terminal-count flag.
module mem_wait_counter
  import mem_stage_pkg::*;
#(
  parameter int CNT_W  = WAIT_CNT_W,
  parameter int TC_VAL = 14
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Clear wins over enable; hold at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + CNT_W'(1);
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == CNT_W'(TC_VAL));

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues RAM requests, stalls upstream until ack or timeout,
// and loads the MEM/WB register (or a bubble) each cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int WAIT_MAX   = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       emo_alu_answer,
  input  logic [DATA_W-1:0]       emo_ram_write_data,
  input  logic [MEM_OP_W-1:0]     emo_mem_op,
  input  logic [WB_DATA_OP_W-1:0] emo_wb_data_op,
  input  logic [REG_OP_W-1:0]     emo_reg_op,
  input  logic [REG_ADDR_W-1:0]   emo_wb_addr,
  input  logic [DATA_W-1:0]       emo_PC_wb_data,
  input  logic [DATA_W-1:0]       emo_IH_wb_data,
  output logic [DATA_W-1:0]       mwo_alu_answer,
  output logic [DATA_W-1:0]       mwo_ram_read_answer,
  output logic [DATA_W-1:0]       mwo_PC_wb_data,
  output logic [DATA_W-1:0]       mwo_IH_wb_data,
  output logic [REG_ADDR_W-1:0]   mwo_wb_addr,
  output logic [REG_OP_W-1:0]     mwo_reg_op,
  output logic [WB_DATA_OP_W-1:0] mwo_wb_data_op,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [DATA_W-1:0]       ram_addr,
  output logic [DATA_W-1:0]       ram_wdata,
  input  logic                    ram_ack,
  input  logic [DATA_W-1:0]       ram_rdata,
  output logic                    mem_stall,
  output logic                    mem_err
);

  localparam logic [DATA_W-1:0] ZERO = DATA_ZERO[DATA_W-1:0];

  mem_state_e state_q, state_d;
  logic       tc;
  logic       cnt_clr, cnt_en;
  logic       issue, load_emo, err_set, stall_c;

  logic                    ram_req_q, ram_we_q;
  logic [DATA_W-1:0]       ram_addr_q, ram_wdata_q;
  logic                    mem_err_q;

  logic [DATA_W-1:0]       mw_alu_q, mw_alu_d;
  logic [DATA_W-1:0]       mw_rd_q, mw_rd_d;
  logic [DATA_W-1:0]       mw_pc_q, mw_pc_d;
  logic [DATA_W-1:0]       mw_ih_q, mw_ih_d;
  logic [REG_ADDR_W-1:0]   mw_wa_q, mw_wa_d;
  logic [REG_OP_W-1:0]     mw_ro_q, mw_ro_d;
  logic [WB_DATA_OP_W-1:0] mw_wo_q, mw_wo_d;

  // Timeout fires on the last allowed wait cycle without an ack.
  mem_wait_counter #(
    .CNT_W  (WAIT_CNT_W),
    .TC_VAL (WAIT_MAX - 1)
  ) u_wait_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .en_i  (cnt_en),
    .tc_o  (tc)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state: every ack or timeout returns to IDLE, forcing a one-cycle request gap.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (is_mem_access(emo_mem_op)) state_d = ST_WAIT;
      ST_WAIT: if (ram_ack || tc)             state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: stall, request issue, MEM/WB load select, counter control.
  always_comb begin
    stall_c  = 1'b0;
    issue    = 1'b0;
    load_emo = 1'b0;
    err_set  = 1'b0;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_clr = 1'b1;
        if (is_mem_access(emo_mem_op)) begin
          stall_c = 1'b1;
          issue   = 1'b1;
        end else begin
          load_emo = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_en = !ram_ack;
        if (ram_ack)  load_emo = 1'b1;
        else if (tc)  err_set  = 1'b1;
        else          stall_c  = 1'b1;
      end
      default: ;
    endcase
  end

  assign mem_stall = rst && stall_c;

  // RAM request registers: captured on issue, held through WAIT, req drops on ack/timeout.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ram_req_q   <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= ZERO;
      ram_wdata_q <= ZERO;
    end else if (issue) begin
      ram_req_q   <= 1'b1;
      ram_we_q    <= (emo_mem_op == MEM_OP_WRITE);
      ram_addr_q  <= emo_alu_answer;
      ram_wdata_q <= emo_ram_write_data;
    end else if ((state_q == ST_WAIT) && (ram_ack || tc)) begin
      ram_req_q   <= 1'b0;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst)         mem_err_q <= 1'b0;
    else if (err_set) mem_err_q <= 1'b1;
  end

  // MEM/WB next value: pass-through on NOP or ack, bubble otherwise.
  always_comb begin
    mw_alu_d = ZERO;
    mw_rd_d  = ZERO;
    mw_pc_d  = ZERO;
    mw_ih_d  = ZERO;
    mw_wa_d  = '0;
    mw_ro_d  = REG_OP_NOP;
    mw_wo_d  = WB_DATA_OP_NOP;
    if (load_emo) begin
      mw_alu_d = emo_alu_answer;
      mw_pc_d  = emo_PC_wb_data;
      mw_ih_d  = emo_IH_wb_data;
      mw_wa_d  = emo_wb_addr;
      mw_ro_d  = emo_reg_op;
      mw_wo_d  = emo_wb_data_op;
      if ((state_q == ST_WAIT) && !ram_we_q) mw_rd_d = ram_rdata;
    end
  end

  // MEM/WB register; reset loads a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mw_alu_q <= ZERO;
      mw_rd_q  <= ZERO;
      mw_pc_q  <= ZERO;
      mw_ih_q  <= ZERO;
      mw_wa_q  <= '0;
      mw_ro_q  <= REG_OP_NOP;
      mw_wo_q  <= WB_DATA_OP_NOP;
    end else begin
      mw_alu_q <= mw_alu_d;
      mw_rd_q  <= mw_rd_d;
      mw_pc_q  <= mw_pc_d;
      mw_ih_q  <= mw_ih_d;
      mw_wa_q  <= mw_wa_d;
      mw_ro_q  <= mw_ro_d;
      mw_wo_q  <= mw_wo_d;
    end
  end

  assign ram_req             = ram_req_q;
  assign ram_we              = ram_we_q;
  assign ram_addr            = ram_addr_q;
  assign ram_wdata           = ram_wdata_q;
  assign mem_err             = mem_err_q;
  assign mwo_alu_answer      = mw_alu_q;
  assign mwo_ram_read_answer = mw_rd_q;
  assign mwo_PC_wb_data      = mw_pc_q;
  assign mwo_IH_wb_data      = mw_ih_q;
  assign mwo_wb_addr         = mw_wa_q;
  assign mwo_reg_op          = mw_ro_q;
  assign mwo_wb_data_op      = mw_wo_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: stimulus pushes expected MEM/WB words,
// a negedge monitor pops and compares every non-NOP MEM/WB output.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] emo_alu_answer, emo_ram_write_data, emo_PC_wb_data, emo_IH_wb_data;
  logic [1:0]  emo_mem_op, emo_wb_data_op, emo_reg_op;
  logic [3:0]  emo_wb_addr;
  logic [15:0] mwo_alu_answer, mwo_ram_read_answer, mwo_PC_wb_data, mwo_IH_wb_data;
  logic [3:0]  mwo_wb_addr;
  logic [1:0]  mwo_reg_op, mwo_wb_data_op;
  logic        ram_req, ram_we, ram_ack, mem_stall, mem_err;
  logic [15:0] ram_addr, ram_wdata, ram_rdata;

  typedef struct packed {
    logic [15:0] alu, rd, pc, ih;
    logic [3:0]  wa;
    logic [1:0]  ro, wo;
  } mw_t;

  mw_t exp_q[$];
  int  tests = 0;
  int  fails = 0;

  mem_stage #(.DATA_W(16), .REG_ADDR_W(4), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst),
    .emo_alu_answer(emo_alu_answer), .emo_ram_write_data(emo_ram_write_data),
    .emo_mem_op(emo_mem_op), .emo_wb_data_op(emo_wb_data_op), .emo_reg_op(emo_reg_op),
    .emo_wb_addr(emo_wb_addr), .emo_PC_wb_data(emo_PC_wb_data), .emo_IH_wb_data(emo_IH_wb_data),
    .mwo_alu_answer(mwo_alu_answer), .mwo_ram_read_answer(mwo_ram_read_answer),
    .mwo_PC_wb_data(mwo_PC_wb_data), .mwo_IH_wb_data(mwo_IH_wb_data),
    .mwo_wb_addr(mwo_wb_addr), .mwo_reg_op(mwo_reg_op), .mwo_wb_data_op(mwo_wb_data_op),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .mem_stall(mem_stall), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    emo_mem_op = MEM_OP_NOP; emo_alu_answer = 16'h0; emo_ram_write_data = 16'h0;
    emo_wb_data_op = WB_DATA_OP_NOP; emo_reg_op = REG_OP_NOP; emo_wb_addr = 4'h0;
    emo_PC_wb_data = 16'h0; emo_IH_wb_data = 16'h0;
  endtask

  // Entered and left just after a rising edge.
  task automatic alu_op(input logic [15:0] alu, input logic [3:0] wa, input logic [15:0] pc);
    mw_t e;
    emo_mem_op = MEM_OP_NOP; emo_alu_answer = alu; emo_ram_write_data = 16'h0;
    emo_reg_op = REG_OP_REG; emo_wb_data_op = WB_DATA_OP_ALU; emo_wb_addr = wa;
    emo_PC_wb_data = pc; emo_IH_wb_data = ~pc;
    e = '{alu: alu, rd: 16'h0, pc: pc, ih: ~pc, wa: wa, ro: REG_OP_REG, wo: WB_DATA_OP_ALU};
    exp_q.push_back(e);
    @(negedge clk); chk("alu_no_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1; set_idle();
  endtask

  // Memory op acked on WAIT cycle ack_at (1-based); expect ack_at stall cycles.
  task automatic mem_op(input logic [1:0] op, input logic [15:0] addr, input logic [15:0] wd,
                        input logic [15:0] rdata, input int ack_at, input logic [3:0] wa,
                        input logic [1:0] ro, input logic [1:0] wo, input logic [15:0] pc);
    mw_t e;
    int  stalls = 0;
    emo_mem_op = op; emo_alu_answer = addr; emo_ram_write_data = wd;
    emo_reg_op = ro; emo_wb_data_op = wo; emo_wb_addr = wa;
    emo_PC_wb_data = pc; emo_IH_wb_data = ~pc;
    e = '{alu: addr, rd: (op == MEM_OP_READ) ? rdata : 16'h0, pc: pc, ih: ~pc, wa: wa, ro: ro, wo: wo};
    exp_q.push_back(e);
    for (int c = 0; c <= ack_at; c++) begin
      ram_ack   = (c == ack_at) && (c > 0);
      ram_rdata = ram_ack ? rdata : 16'hDEAD;
      @(negedge clk);
      if (mem_stall) stalls++;
      if (c == 0) chk("req_gap_before_issue", {31'd0, ram_req}, 32'd0);
      if (c == 1) begin
        chk("ram_req_wait", {31'd0, ram_req}, 32'd1);
        chk("ram_we", {31'd0, ram_we}, {31'd0, op == MEM_OP_WRITE});
        chk("ram_addr", {16'd0, ram_addr}, {16'd0, addr});
        chk("ram_wdata", {16'd0, ram_wdata}, {16'd0, wd});
      end
      @(posedge clk); #1;
    end
    ram_ack = 1'b0; ram_rdata = 16'h0;
    set_idle();
    chk("stall_cycles", stalls, ack_at);
  endtask

  // Scoreboard monitor: every non-NOP MEM/WB word must match the next expectation.
  always @(negedge clk) begin : mon
    mw_t a, e;
    if (mwo_reg_op != REG_OP_NOP) begin
      a = '{alu: mwo_alu_answer, rd: mwo_ram_read_answer, pc: mwo_PC_wb_data, ih: mwo_IH_wb_data,
            wa: mwo_wb_addr, ro: mwo_reg_op, wo: mwo_wb_data_op};
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL mw_unexpected: got %h expected nothing", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          fails++;
          $display("FAIL mw_out: got %h expected %h", a, e);
        end
      end
    end
  end

  initial begin
    int stalls;
    bit done;
    rst = 1'b0; ram_ack = 1'b0; ram_rdata = 16'h0;
    set_idle();
    emo_mem_op = MEM_OP_READ;   // stall must stay low while in reset
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_req", {31'd0, ram_req}, 32'd0);
    chk("rst_err", {31'd0, mem_err}, 32'd0);
    chk("rst_reg_op", {30'd0, mwo_reg_op}, 32'd0);
    chk("rst_alu", {16'd0, mwo_alu_answer}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; set_idle();
    @(posedge clk); #1;

    // plain ALU pass-through
    alu_op(16'h1234, 4'd3, 16'h1111);
    // READ acked on third WAIT cycle
    mem_op(MEM_OP_READ, 16'h0040, 16'h7777, 16'hBEEF, 3, 4'd5, REG_OP_REG, WB_DATA_OP_MEM, 16'h0100);
    @(negedge clk); chk("req_low_after_read", {31'd0, ram_req}, 32'd0);
    @(posedge clk); #1;
    // WRITE acked on first WAIT cycle; read answer must be zero despite rdata
    mem_op(MEM_OP_WRITE, 16'h0010, 16'h00FF, 16'h5A5A, 1, 4'd0, REG_OP_SP, WB_DATA_OP_NOP, 16'h0200);
    @(negedge clk); chk("req_low_after_write", {31'd0, ram_req}, 32'd0);
    @(posedge clk); #1;
    // back-to-back reads; gap checked at issue of the second
    mem_op(MEM_OP_READ, 16'h0080, 16'h0000, 16'h1111, 1, 4'd6, REG_OP_REG, WB_DATA_OP_MEM, 16'h0300);
    mem_op(MEM_OP_READ, 16'h0082, 16'h0000, 16'h2222, 1, 4'd7, REG_OP_REG, WB_DATA_OP_MEM, 16'h0304);
    @(negedge clk); chk("req_low_after_b2b", {31'd0, ram_req}, 32'd0);
    @(posedge clk); #1;

    // READ never acked: timeout
    emo_mem_op = MEM_OP_READ; emo_alu_answer = 16'h0300;
    emo_reg_op = REG_OP_REG; emo_wb_data_op = WB_DATA_OP_MEM; emo_wb_addr = 4'd8;
    stalls = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (mem_stall) begin
        stalls++;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
    end
    chk("timeout_reached", {31'd0, done}, 32'd1);
    chk("timeout_stalls", stalls, 15);
    @(posedge clk); #1;
    set_idle();
    @(negedge clk);
    chk("timeout_err", {31'd0, mem_err}, 32'd1);
    chk("timeout_req", {31'd0, ram_req}, 32'd0);
    chk("timeout_bubble_ro", {30'd0, mwo_reg_op}, 32'd0);
    chk("timeout_bubble_alu", {16'd0, mwo_alu_answer}, 32'd0);
    @(posedge clk); #1;
    alu_op(16'hCAFE, 4'd9, 16'h0400);
    @(negedge clk); chk("err_sticky", {31'd0, mem_err}, 32'd1);
    @(posedge clk); #1;

    // reset on the second WAIT cycle, then a late ack
    emo_mem_op = MEM_OP_READ; emo_alu_answer = 16'h0500;
    emo_reg_op = REG_OP_REG; emo_wb_data_op = WB_DATA_OP_MEM; emo_wb_addr = 4'd2;
    @(posedge clk); #1;   // WAIT cycle 1
    @(posedge clk); #1;   // WAIT cycle 2
    rst = 1'b0;
    @(negedge clk); chk("rst_mid_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1; set_idle(); ram_ack = 1'b1; ram_rdata = 16'h9999;
    @(negedge clk);
    chk("rst_mid_req", {31'd0, ram_req}, 32'd0);
    chk("rst_mid_stall2", {31'd0, mem_stall}, 32'd0);
    chk("rst_mid_ro", {30'd0, mwo_reg_op}, 32'd0);
    chk("rst_mid_err", {31'd0, mem_err}, 32'd0);
    @(posedge clk); #1;
    ram_ack = 1'b0; ram_rdata = 16'h0;
    @(negedge clk);
    chk("late_ack_req", {31'd0, ram_req}, 32'd0);
    chk("late_ack_rd", {16'd0, mwo_ram_read_answer}, 32'd0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
